// File: rtl/mp_reg_file.sv
// Multi-port register file: two write ports, NUM_RD combinational read ports,
// optional hardwired r0, same-cycle write bypass and a sequential clear sweep.
module mp_reg_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 3,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wen0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     wen1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              we0, we1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= (state == SWEEP) ? clr_idx + ADDR_W'(1) : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      clr_done  = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) state_nxt = SWEEP;
         end
         SWEEP: begin
            busy = 1'b1;
            if (clr_idx == LAST_IDX) begin
               clr_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Effective write strobes: dropped during a sweep and for a hardwired r0.
   assign we0 = wen0 && !busy && !(ZERO_REG != 0 && wa0 == '0);
   assign we1 = wen1 && !busy && !(ZERO_REG != 0 && wa1 == '0);

   // Port 1 is written last so it wins an address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (busy) begin
         regs[clr_idx] <= '0;
      end else begin
         if (we0) regs[wa0] <= wd0;
         if (we1) regs[wa1] <= wd1;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = ra[g*ADDR_W +: ADDR_W];

      always_comb begin
         data = regs[addr];
         if (BYPASS != 0) begin
            if (we0 && wa0 == addr) data = wd0;
            if (we1 && wa1 == addr) data = wd1;
         end
         if (ZERO_REG != 0 && addr == '0) data = '0;
      end

      assign rd[g*DATA_W +: DATA_W] = data;
   end

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file: default-parameter instance against a behavioural model,
// plus a small non-bypass, writable-r0 instance exercised by hand.
module tb_mp_reg_file;

   logic        clk;
   logic        reset, wen0, wen1, clr_req;
   logic [4:0]  wa0, wa1;
   logic [31:0] wd0, wd1;
   logic [14:0] ra;
   logic [95:0] rd;
   logic        busy, clr_done;

   logic        s_reset, s_wen0, s_wen1, s_clr_req;
   logic [2:0]  s_wa0, s_wa1, s_ra;
   logic [15:0] s_wd0, s_wd1, s_rd;
   logic        s_busy, s_done;

   int n_tests = 0;
   int n_fail  = 0;

   mp_reg_file dut (
      .clk(clk), .reset(reset),
      .wen0(wen0), .wa0(wa0), .wd0(wd0),
      .wen1(wen1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd),
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   mp_reg_file #(.DATA_W(16), .ADDR_W(3), .NUM_RD(1), .ZERO_REG(0), .BYPASS(0)) dut_s (
      .clk(clk), .reset(s_reset),
      .wen0(s_wen0), .wa0(s_wa0), .wd0(s_wd0),
      .wen1(s_wen1), .wa1(s_wa1), .wd1(s_wd1),
      .ra(s_ra), .rd(s_rd),
      .clr_req(s_clr_req), .busy(s_busy), .clr_done(s_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: register contents plus the index being cleared (-1 = no sweep).
   logic [31:0] mem [32];
   int          sweep_pos = -1;
   bit          model_valid = 1'b0;

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (sweep_pos < 0) begin
         if (wen1 && wa1 == a) return wd1;
         if (wen0 && wa0 == a) return wd0;
      end
      return mem[a];
   endfunction

   task automatic model_step();
      if (reset) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'h0;
         sweep_pos   = -1;
         model_valid = 1'b1;
      end else if (sweep_pos >= 0) begin
         mem[sweep_pos] = 32'h0;
         sweep_pos = (sweep_pos == 31) ? -1 : sweep_pos + 1;
      end else begin
         if (wen0 && wa0 != 5'd0) mem[wa0] = wd0;
         if (wen1 && wa1 != 5'd0) mem[wa1] = wd1;
         if (clr_req) sweep_pos = 0;
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic apply();
      #1;
      if (model_valid) begin
         chk("busy", busy, sweep_pos >= 0);
         chk("clr_done", clr_done, sweep_pos == 31);
         for (int i = 0; i < 3; i++)
            chk($sformatf("rd%0d", i), rd[i*32 +: 32], exp_rd(ra[i*5 +: 5]));
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      reset = 1'b0; clr_req = 1'b0;
      wen0 = 1'b0; wa0 = 5'd0; wd0 = 32'h0;
      wen1 = 1'b0; wa1 = 5'd0; wd1 = 32'h0;
   endtask

   task automatic s_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      bit          rst;
      bit          w0;
      logic [4:0]  a0;
      logic [31:0] d0;
      bit          w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  r0, r1, r2;
      bit          chk;
      logic [31:0] e0, e1, e2;
   } vec_t;

   vec_t tbl [9];

   int nb, ndone, done_at;

   initial begin
      drive_idle();
      ra = 15'h0;
      s_reset = 1'b1; s_clr_req = 1'b0;
      s_wen0 = 1'b0; s_wa0 = 3'd0; s_wd0 = 16'h0;
      s_wen1 = 1'b0; s_wa1 = 3'd0; s_wd1 = 16'h0;
      s_ra = 3'd0;

      tbl[0] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,5'd0,5'd0,   1'b0, 32'h0,32'h0,32'h0};
      tbl[1] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd3,5'd17,5'd31, 1'b1, 32'h0,32'h0,32'h0};
      tbl[2] = '{1'b0, 1'b1,5'd1,32'h0000FFFF, 1'b1,5'd2,32'hFFFF0000, 5'd0,5'd1,5'd2,   1'b1, 32'h0,32'h0000FFFF,32'hFFFF0000};
      tbl[3] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,5'd1,5'd2,   1'b1, 32'h0,32'h0000FFFF,32'hFFFF0000};
      tbl[4] = '{1'b0, 1'b1,5'd5,32'h11111111, 1'b1,5'd5,32'h22222222, 5'd5,5'd1,5'd5,   1'b1, 32'h22222222,32'h0000FFFF,32'h22222222};
      tbl[5] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd5,5'd0,5'd2,   1'b1, 32'h22222222,32'h0,32'hFFFF0000};
      tbl[6] = '{1'b0, 1'b1,5'd0,32'hDEADBEEF, 1'b1,5'd3,32'h12345678, 5'd0,5'd3,5'd5,   1'b1, 32'h0,32'h12345678,32'h22222222};
      tbl[7] = '{1'b0, 1'b0,5'd0,32'h0,        1'b1,5'd0,32'hDEADBEEF, 5'd0,5'd0,5'd3,   1'b1, 32'h0,32'h0,32'h12345678};
      tbl[8] = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        5'd0,5'd3,5'd1,   1'b1, 32'h0,32'h12345678,32'h0000FFFF};

      @(negedge clk);

      // Directed vectors: reset, dual write, collision, hardwired r0.
      for (int v = 0; v < 9; v++) begin
         reset = tbl[v].rst; clr_req = 1'b0;
         wen0 = tbl[v].w0; wa0 = tbl[v].a0; wd0 = tbl[v].d0;
         wen1 = tbl[v].w1; wa1 = tbl[v].a1; wd1 = tbl[v].d1;
         ra = {tbl[v].r2, tbl[v].r1, tbl[v].r0};
         #1;
         if (tbl[v].chk) begin
            chk($sformatf("vec%0d_rd0", v), rd[31:0],  tbl[v].e0);
            chk($sformatf("vec%0d_rd1", v), rd[63:32], tbl[v].e1);
            chk($sformatf("vec%0d_rd2", v), rd[95:64], tbl[v].e2);
            chk($sformatf("vec%0d_busy", v), busy, 1'b0);
         end
         apply();
      end

      // Fill r1..r31, then start a clear together with a write to r7.
      for (int r = 1; r < 32; r++) begin
         drive_idle();
         wen0 = 1'b1; wa0 = 5'(r); wd0 = $urandom | 32'h1;
         ra = {5'(r), 5'(r - 1), 5'd0};
         apply();
      end
      drive_idle();
      clr_req = 1'b1; wen1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77777777;
      ra = {5'd7, 5'd7, 5'd7};
      apply();

      nb = 0; ndone = 0; done_at = 0;
      for (int c = 0; c < 40; c++) begin
         if (!busy) break;
         nb++;
         drive_idle();
         clr_req = 1'b1;
         wen0 = 1'b1; wa0 = 5'($urandom); wd0 = $urandom;
         wen1 = 1'b1; wa1 = 5'($urandom); wd1 = $urandom;
         ra = (c == 0) ? {5'd1, 5'd30, 5'd7} : 15'($urandom);
         #1;
         if (c == 0) chk("sweep_r7_committed", rd[31:0], 32'h77777777);
         if (clr_done) begin
            ndone++;
            done_at = nb;
         end
         apply();
      end
      chk("sweep_busy_cycles", nb, 32);
      chk("sweep_done_pulses", ndone, 1);
      chk("sweep_done_cycle", done_at, 32);

      drive_idle();
      for (int r = 0; r < 33; r += 3) begin
         ra = {5'(r + 2), 5'(r + 1), 5'(r)};
         #1;
         chk($sformatf("cleared_r%0d", r), rd, 96'h0);
         apply();
      end
      chk("idle_after_sweep", busy, 1'b0);

      // Reset in the tenth sweep cycle.
      drive_idle();
      wen0 = 1'b1; wa0 = 5'd20; wd0 = 32'hCAFEF00D;
      apply();
      drive_idle();
      clr_req = 1'b1;
      apply();
      ndone = 0;
      for (int c = 1; c < 10; c++) begin
         drive_idle();
         #1 if (clr_done) ndone++;
         apply();
      end
      drive_idle();
      reset = 1'b1; clr_req = 1'b1;
      wen0 = 1'b1; wa0 = 5'd12; wd0 = 32'h12121212;
      #1 if (clr_done) ndone++;
      chk("abort_busy_before", busy, 1'b1);
      apply();
      drive_idle();
      wen0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5;
      ra = {5'd12, 5'd20, 5'd9};
      #1 if (clr_done) ndone++;
      chk("abort_busy_after", busy, 1'b0);
      chk("abort_bypass", rd, {32'h0, 32'h0, 32'hA5A5A5A5});
      apply();
      drive_idle();
      ra = {5'd12, 5'd20, 5'd9};
      #1;
      chk("abort_write_commit", rd, {32'h0, 32'h0, 32'hA5A5A5A5});
      chk("abort_no_done", ndone, 0);
      apply();

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         reset   = ($urandom_range(0, 99) == 0);
         clr_req = ($urandom_range(0, 39) == 0);
         wen0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom;
         wen1 = 1'($urandom);
         wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom);
         wd1 = $urandom;
         ra = {($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom),
               ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom),
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom)};
         apply();
      end
      drive_idle();

      // Small instance: writable r0, no bypass, 8-cycle clear.
      s_cyc();
      s_reset = 1'b0;
      s_wen0 = 1'b1; s_wa0 = 3'd0; s_wd0 = 16'h1234; s_ra = 3'd0;
      #1 chk("s_r0_old_during_write", s_rd, 16'h0);
      s_cyc();
      s_wen0 = 1'b0;
      #1 chk("s_r0_writable", s_rd, 16'h1234);
      s_wen0 = 1'b1; s_wa0 = 3'd3; s_wd0 = 16'h1111;
      s_wen1 = 1'b1; s_wa1 = 3'd3; s_wd1 = 16'hBEEF; s_ra = 3'd3;
      #1 chk("s_no_bypass", s_rd, 16'h0);
      s_cyc();
      s_wen0 = 1'b0; s_wen1 = 1'b0;
      #1 chk("s_collision_port1", s_rd, 16'hBEEF);
      s_clr_req = 1'b1;
      s_cyc();
      s_clr_req = 1'b0;
      nb = 0; done_at = 0; ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (!s_busy) break;
         nb++;
         if (s_done) begin
            ndone++;
            done_at = nb;
         end
         s_cyc();
      end
      chk("s_sweep_cycles", nb, 8);
      chk("s_done_cycle", done_at, 8);
      chk("s_done_pulses", ndone, 1);
      s_ra = 3'd0;
      #1 chk("s_r0_cleared", s_rd, 16'h0);
      s_ra = 3'd3;
      #1 chk("s_r3_cleared", s_rd, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
